// File: rtl/uart_autobaud_if.sv
// Control/status bundle between the autobaud detector and its host sequencer.
// The detector side uses the slave modport and the host side uses the master modport.
interface uart_autobaud_if #(
    parameter int unsigned DIV_WIDTH = 16
);
    logic                 start_i;
    logic                 rx_i;
    logic                 busy_o;
    logic                 done_o;
    logic                 err_o;
    logic [DIV_WIDTH-1:0] div_o;
    logic                 div_valid_o;

    modport master (
        output start_i, rx_i,
        input  busy_o, done_o, err_o, div_o, div_valid_o
    );

    modport slave (
        input  start_i, rx_i,
        output busy_o, done_o, err_o, div_o, div_valid_o
    );
endinterface

// File: rtl/uart_autobaud.sv
// UART autobaud detector: times a 0x55 sync character and produces a rounded
// clocks-per-bit divisor for the UART DIV register.
module uart_autobaud #(
    parameter int unsigned DIV_WIDTH = 16,
    parameter int unsigned MIN_DIV   = 4,
    parameter int unsigned CNT_WIDTH = DIV_WIDTH + 3
) (
    input  logic          clk_i,
    input  logic          rst_i,
    uart_autobaud_if.slave bus
);

    localparam int unsigned RND_WIDTH = CNT_WIDTH + 1;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_HUNT    = 2'd1;
    localparam logic [1:0] S_MEASURE = 2'd2;
    localparam logic [1:0] S_STOP    = 2'd3;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    logic                 r_rx_meta, r_rx_sync, r_rx_prev;
    logic [1:0]           r_state, w_state_nx;
    logic [CNT_WIDTH-1:0] r_cnt, w_cnt_nx;
    logic [CNT_WIDTH-1:0] r_per, w_per_nx;
    logic [CNT_WIDTH-1:0] r_p0, w_p0_nx;
    logic [CNT_WIDTH-1:0] r_t8, w_t8_nx;
    logic [2:0]           r_pcnt, w_pcnt_nx;
    logic                 r_hi, w_hi_nx;
    logic                 r_busy;
    logic                 r_done, w_done_nx;
    logic                 r_err, w_err_nx;
    logic [DIV_WIDTH-1:0] r_div, w_div_nx;
    logic                 r_vld, w_vld_nx;

    logic                 w_fall, w_rise, w_timeout;
    logic [CNT_WIDTH-1:0] w_dev, w_tol, w_half, w_low_min, w_low_max;
    logic [RND_WIDTH-1:0] w_rnd;
    logic [DIV_WIDTH-1:0] w_div;

    // Line synchronizer plus edge-history flop; idles high like the line.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_meta <= bus.rx_i;
            r_rx_sync <= r_rx_meta;
            r_rx_prev <= r_rx_sync;
        end
    end

    assign w_fall    = r_rx_prev & ~r_rx_sync;
    assign w_rise    = ~r_rx_prev & r_rx_sync;
    assign w_timeout = (r_cnt == CNT_MAX) || (r_per == CNT_MAX);
    assign w_dev     = (r_per >= r_p0) ? (r_per - r_p0) : (r_p0 - r_per);
    assign w_tol     = r_p0 >> 3;
    assign w_half    = r_p0 >> 1;
    assign w_low_min = w_half - w_tol;
    assign w_low_max = w_half + w_tol;
    assign w_rnd     = RND_WIDTH'(r_t8) + RND_WIDTH'(4);
    assign w_div     = DIV_WIDTH'(w_rnd >> 3);

    // Next-state logic; an arm pulse outside IDLE restarts silently.
    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_per_nx   = r_per;
        w_p0_nx    = r_p0;
        w_t8_nx    = r_t8;
        w_pcnt_nx  = r_pcnt;
        w_hi_nx    = r_hi;
        w_done_nx  = 1'b0;
        w_err_nx   = 1'b0;
        w_div_nx   = r_div;
        w_vld_nx   = r_vld;
        if (bus.start_i && (r_state != S_IDLE)) begin
            w_state_nx = S_HUNT;
            w_cnt_nx   = '0;
            w_per_nx   = '0;
            w_p0_nx    = '0;
            w_pcnt_nx  = '0;
            w_hi_nx    = 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_cnt_nx  = '0;
                    w_per_nx  = '0;
                    w_p0_nx   = '0;
                    w_pcnt_nx = '0;
                    w_hi_nx   = 1'b0;
                    if (bus.start_i) w_state_nx = S_HUNT;
                end
                S_HUNT: begin
                    if (w_fall) begin
                        w_cnt_nx   = CNT_WIDTH'(1);
                        w_per_nx   = CNT_WIDTH'(1);
                        w_pcnt_nx  = '0;
                        w_state_nx = S_MEASURE;
                    end
                end
                S_MEASURE: begin
                    if (w_timeout) begin
                        w_err_nx   = 1'b1;
                        w_state_nx = S_IDLE;
                    end else begin
                        w_cnt_nx = r_cnt + CNT_WIDTH'(1);
                        w_per_nx = r_per + CNT_WIDTH'(1);
                        if (w_fall) begin
                            w_per_nx = CNT_WIDTH'(1);
                            if (r_pcnt == 3'd0) begin
                                w_p0_nx   = r_per;
                                w_pcnt_nx = 3'd1;
                            end else if (w_dev > w_tol) begin
                                w_err_nx   = 1'b1;
                                w_state_nx = S_IDLE;
                            end else if (r_pcnt == 3'd3) begin
                                w_t8_nx    = r_cnt;
                                w_hi_nx    = 1'b0;
                                w_state_nx = S_STOP;
                            end else begin
                                w_pcnt_nx = r_pcnt + 3'd1;
                            end
                        end
                    end
                end
                S_STOP: begin
                    // r_hi=0 times the b7 low half; r_hi=1 times the stop-bit high window.
                    if (w_timeout || w_fall) begin
                        w_err_nx   = 1'b1;
                        w_state_nx = S_IDLE;
                    end else begin
                        w_cnt_nx = r_cnt + CNT_WIDTH'(1);
                        w_per_nx = r_per + CNT_WIDTH'(1);
                        if (!r_hi) begin
                            if (w_rise) begin
                                if ((r_per >= w_low_min) && (r_per <= w_low_max)) begin
                                    w_hi_nx  = 1'b1;
                                    w_per_nx = CNT_WIDTH'(1);
                                end else begin
                                    w_err_nx   = 1'b1;
                                    w_state_nx = S_IDLE;
                                end
                            end
                        end else if (r_per == w_half) begin
                            w_state_nx = S_IDLE;
                            if (w_div < DIV_WIDTH'(MIN_DIV)) begin
                                w_err_nx = 1'b1;
                            end else begin
                                w_done_nx = 1'b1;
                                w_div_nx  = w_div;
                                w_vld_nx  = 1'b1;
                            end
                        end
                    end
                end
                default: w_state_nx = S_IDLE;
            endcase
        end
    end

    // State and output registers; busy lags state so it drops after the pulse.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_per   <= '0;
            r_p0    <= '0;
            r_t8    <= '0;
            r_pcnt  <= '0;
            r_hi    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_div   <= '0;
            r_vld   <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_per   <= w_per_nx;
            r_p0    <= w_p0_nx;
            r_t8    <= w_t8_nx;
            r_pcnt  <= w_pcnt_nx;
            r_hi    <= w_hi_nx;
            r_busy  <= (r_state != S_IDLE);
            r_done  <= w_done_nx;
            r_err   <= w_err_nx;
            r_div   <= w_div_nx;
            r_vld   <= w_vld_nx;
        end
    end

    assign bus.busy_o      = r_busy;
    assign bus.done_o      = r_done;
    assign bus.err_o       = r_err;
    assign bus.div_o       = r_div;
    assign bus.div_valid_o = r_vld;

endmodule

// File: tb/tb_uart_autobaud.sv
// Bench for uart_autobaud: line waveforms are built as level/length segments and
// the expected outcome is derived from the edge timeline of that waveform.
module tb_uart_autobaud;

    // Narrow divisor keeps the frame-counter saturation case short.
    localparam int unsigned DW      = 10;
    localparam int unsigned CW      = DW + 3;
    localparam int          CNT_MAX = (1 << CW) - 1;
    localparam int          MIN_DIV = 4;
    localparam int          TAIL    = 200;
    localparam int          INF     = 1 << 30;

    logic clk = 1'b0;
    logic rst;

    uart_autobaud_if #(.DIV_WIDTH(DW)) ab_if ();

    uart_autobaud #(.DIV_WIDTH(DW), .MIN_DIV(MIN_DIV)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (ab_if)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;
    int seg_len[$];
    bit seg_lvl[$];
    int start_seg;
    int exp_div = 0;
    bit exp_vld = 1'b0;
    int m_kind, m_t, m_div;
    bit m_to;

    task automatic check(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int abs_i(input int v);
        return (v < 0) ? -v : v;
    endfunction

    task automatic add_seg(input bit lvl, input int len);
        seg_lvl.push_back(lvl);
        seg_len.push_back(len);
    endtask

    task automatic new_wave();
        seg_len.delete();
        seg_lvl.delete();
        start_seg = 0;
        add_seg(1'b1, 10);
    endtask

    // mode 0: fixed, 1: +1 on odd bits, 2: +1 on even bits from b1, 3: random +/-1
    task automatic add_frame(input logic [7:0] b, input int base, input int mode);
        for (int i = 0; i < 10; i++) begin
            bit lvl;
            int len;
            lvl = (i == 0) ? 1'b0 : (i == 9) ? 1'b1 : b[i-1];
            case (mode)
                0:       len = base;
                1:       len = base + (i % 2);
                2:       len = base + (((i >= 2) && (i % 2 == 0)) ? 1 : 0);
                default: len = base + int'($urandom_range(0, 2)) - 1;
            endcase
            add_seg(lvl, len);
        end
        add_seg(1'b1, TAIL);
    endtask

    // Outcome from edge times (cycles since wave start); DUT reacts 3 edges after a line change.
    task automatic run_model();
        int t, f0, p0, tol, half, t_dec, r, g, t8, lval;
        bit prev;
        int fq[$];
        int rq[$];
        t = 0;
        prev = 1'b1;
        for (int i = 0; i < seg_len.size(); i++) begin
            if ((i >= start_seg) && (seg_lvl[i] != prev)) begin
                if (seg_lvl[i] == 1'b0) fq.push_back(t);
                else rq.push_back(t);
            end
            prev = seg_lvl[i];
            t += seg_len[i];
        end
        m_kind = 0;
        m_t    = -1;
        m_div  = exp_div;
        m_to   = 1'b0;
        if (fq.size() == 0) return;
        f0     = fq[0];
        t_dec  = INF;
        m_kind = 2;
        if (fq.size() >= 2) begin
            p0   = fq[1] - f0;
            tol  = p0 >> 3;
            half = p0 >> 1;
            for (int n = 2; (n <= 4) && (n < fq.size()); n++) begin
                if (abs_i(fq[n] - fq[n-1] - p0) > tol) begin
                    t_dec = fq[n];
                    break;
                end
                if (n == 4) begin
                    t8 = fq[4] - f0;
                    r  = -1;
                    foreach (rq[k]) if ((r < 0) && (rq[k] > fq[4])) r = rq[k];
                    if (r >= 0) begin
                        lval = r - fq[4];
                        if ((lval < half - tol) || (lval > half + tol)) begin
                            t_dec = r;
                        end else begin
                            g = -1;
                            foreach (fq[k]) if ((g < 0) && (fq[k] > r)) g = fq[k];
                            if ((g >= 0) && (g <= r + half)) begin
                                t_dec = g;
                            end else begin
                                t_dec = r + half;
                                if (((t8 + 4) >> 3) >= MIN_DIV) begin
                                    m_kind = 1;
                                    m_div  = ((t8 + 4) >> 3) % (1 << DW);
                                end
                            end
                        end
                    end
                end
            end
        end
        if (t_dec - f0 >= CNT_MAX) begin
            m_kind = 2;
            m_div  = exp_div;
            t_dec  = f0 + CNT_MAX;
            m_to   = 1'b1;
        end
        m_t = t_dec + 3;
    endtask

    task automatic run_case(input string name);
        int total, budget, n_done, n_err, both, t_pulse, busy_p, busy_a;
        run_model();
        total = 0;
        foreach (seg_len[i]) total += seg_len[i];
        budget  = total + 60;
        n_done  = 0;
        n_err   = 0;
        both    = 0;
        t_pulse = -1;
        busy_p  = -1;
        busy_a  = -1;
        @(posedge clk);
        #1;
        fork
            begin
                for (int i = 0; i < seg_len.size(); i++) begin
                    ab_if.rx_i = seg_lvl[i];
                    if ((i == 0) || (i == start_seg)) ab_if.start_i = 1'b1;
                    repeat (seg_len[i]) begin
                        @(posedge clk);
                        #1;
                        ab_if.start_i = 1'b0;
                    end
                end
            end
            begin
                for (int c = 1; c <= budget; c++) begin
                    @(posedge clk);
                    #1;
                    if ((t_pulse >= 0) && (c == t_pulse + 1)) busy_a = int'(ab_if.busy_o);
                    if (ab_if.done_o) n_done++;
                    if (ab_if.err_o) n_err++;
                    if (ab_if.done_o && ab_if.err_o) both++;
                    if ((ab_if.done_o || ab_if.err_o) && (t_pulse < 0)) begin
                        t_pulse = c;
                        busy_p  = int'(ab_if.busy_o);
                    end
                end
            end
        join
        if (m_kind == 1) begin
            exp_div = m_div;
            exp_vld = 1'b1;
        end
        check({name, ".n_done"}, n_done, (m_kind == 1) ? 1 : 0);
        check({name, ".n_err"}, n_err, (m_kind == 2) ? 1 : 0);
        check({name, ".both"}, both, 0);
        if (m_kind != 0) begin
            check({name, ".latency"}, t_pulse, m_t);
            check({name, ".busy_at_pulse"}, busy_p, 1);
            check({name, ".busy_after"}, busy_a, 0);
        end
        check({name, ".div"}, int'(ab_if.div_o), exp_div);
        check({name, ".div_valid"}, int'(ab_if.div_valid_o), int'(exp_vld));
    endtask

    initial begin
        logic [7:0] b;
        int base;
        rst           = 1'b1;
        ab_if.start_i = 1'b0;
        ab_if.rx_i    = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset.busy", int'(ab_if.busy_o), 0);
        check("reset.done", int'(ab_if.done_o), 0);
        check("reset.err", int'(ab_if.err_o), 0);
        check("reset.div", int'(ab_if.div_o), 0);
        check("reset.div_valid", int'(ab_if.div_valid_o), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(posedge clk);

        new_wave(); add_frame(8'h55, 100, 0); run_case("u100");
        check("u100.div_abs", int'(ab_if.div_o), 100);
        new_wave(); add_frame(8'h55, 100, 1); run_case("t804");
        check("t804.div_abs", int'(ab_if.div_o), 101);
        new_wave(); add_frame(8'h55, 100, 2); run_case("t803");
        check("t803.div_abs", int'(ab_if.div_o), 100);
        new_wave(); add_frame(8'h41, 100, 0); run_case("x41");
        check("x41.div_kept", int'(ab_if.div_o), 100);
        new_wave(); add_seg(1'b0, CNT_MAX + 100); add_seg(1'b1, 50); run_case("held_low");
        new_wave(); add_frame(8'h55, 3, 0); run_case("div3");

        // Partial frame, re-arm mid-MEASURE, then a clean frame at 50 clk/bit.
        new_wave();
        add_seg(1'b0, 70); add_seg(1'b1, 70); add_seg(1'b0, 35);
        start_seg = seg_len.size();
        add_seg(1'b1, 100);
        add_frame(8'h55, 50, 0);
        run_case("abort");
        check("abort.div_abs", int'(ab_if.div_o), 50);

        for (int k = 0; k < 12; k++) begin
            base = int'($urandom_range(4, 120));
            b    = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h55;
            new_wave(); add_frame(b, base, 3);
            run_model();
            if (m_to) begin
                new_wave(); add_frame(8'h55, base, 3);
            end
            run_case($sformatf("rnd%0d", k));
        end

        // Asynchronous reset in the middle of a measurement after an accept.
        new_wave(); add_frame(8'h55, 80, 0); run_case("pre_rst");
        @(posedge clk); #1;
        ab_if.start_i = 1'b1;
        @(posedge clk); #1;
        ab_if.start_i = 1'b0;
        ab_if.rx_i    = 1'b0;
        repeat (300) @(posedge clk);
        #1;
        check("mid.busy", int'(ab_if.busy_o), 1);
        check("mid.div_valid", int'(ab_if.div_valid_o), 1);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst.busy", int'(ab_if.busy_o), 0);
        check("async_rst.div", int'(ab_if.div_o), 0);
        check("async_rst.div_valid", int'(ab_if.div_valid_o), 0);
        exp_div = 0;
        exp_vld = 1'b0;
        ab_if.rx_i = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        new_wave(); add_frame(8'h55, 60, 0); run_case("post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
